// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths, register-zero index and word/address types
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one combinational read port: array select, r0 force, optional
// write-through forwarding when REG_FILE_BYPASS_EN is defined
module reg_file_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] stored;
  logic              is_zero;
  logic              fwd;

  assign stored  = regs_flat[int'(raddr)*DATA_W +: DATA_W];
  assign is_zero = (raddr == ADDR_W'(REG_ZERO));

`ifdef REG_FILE_BYPASS_EN
  // Forwarding is inhibited during reset so reads never expose a dropped write.
  assign fwd = we && rst_n && (waddr != ADDR_W'(REG_ZERO)) && (raddr == waddr);
`else
  logic unused_bypass;
  assign unused_bypass = ^{rst_n, we, waddr, wdata};
  assign fwd = 1'b0;
`endif

  assign rdata = is_zero ? '0 : (fwd ? wdata : stored);

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - MIPS 32x32 register file, two async reads, one sync write, r0 hardwired;
// REG_FILE_BYPASS_EN enables same-cycle write-through forwarding
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0]          mem_q [NUM_REGS];
  logic [DATA_W-1:0]          mem_d [NUM_REGS];
  logic [NUM_REGS-1:0]        wr_dec;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  // Entry 0 is never decoded, so it stays at its cleared value.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_dec[i] = we && (i != 0) && (waddr == ADDR_W'(i));
      mem_d[i]  = wr_dec[i] ? wdata : mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = mem_q[g];
  end

  reg_file_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd1 (
    .regs_flat (regs_flat),
    .raddr     (raddr1),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata     (rdata1)
  );

  reg_file_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd2 (
    .regs_flat (regs_flat),
    .raddr     (raddr2),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata     (rdata2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed plus random checks of reg_file against an array reference model
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  logic [31:0] model [32];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  function automatic logic [31:0] expect_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (BYPASS && we && rst_n && waddr != 5'd0 && ra == waddr) return wdata;
    return model[ra];
  endfunction

  // Apply one cycle: check combinational reads mid-cycle, then clock and update the model.
  task automatic step(input string tag, input logic r, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    logic [31:0] e1, e2;
    rst_n = r; we = w; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2;
    #2;
    e1 = expect_rd(ra1);
    e2 = expect_rd(ra2);
    vectors++;
    assert (rdata1 === e1) else begin
      miscompares++;
      $error("FAIL %s rdata1 raddr=%0d observed=%h expected=%h", tag, ra1, rdata1, e1);
    end
    vectors++;
    assert (rdata2 === e2) else begin
      miscompares++;
      $error("FAIL %s rdata2 raddr=%0d observed=%h expected=%h", tag, ra2, rdata2, e2);
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic expect_const(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic r, w;
    logic [4:0] wa, ra1, ra2;
    logic [31:0] wd;

    @(posedge clk); #1;
    // Before any reset only r0 is defined.
    step("pre_reset_r0", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Reset clear, with a write attempted during reset.
    step("reset_w5", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    step("reset_cycle", 1'b0, 1'b1, 5'd7, 32'h00001234, 5'd5, 5'd7);
    step("reset_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    expect_const("reset_r5_zero", rdata1, 32'h0);
    expect_const("reset_r7_zero", rdata2, 32'h0);

    // Basic write/read.
    step("basic_w8", 1'b1, 1'b1, 5'd8, 32'h000000AA, 5'd0, 5'd0);
    step("basic_w31", 1'b1, 1'b1, 5'd31, 32'hFFFF0001, 5'd8, 5'd0);
    step("basic_read", 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd31);
    expect_const("basic_r8", rdata1, 32'h000000AA);
    expect_const("basic_r31", rdata2, 32'hFFFF0001);

    // Zero register, including the write cycle itself.
    step("zero_write", 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step("zero_read", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    expect_const("zero_r0", rdata1, 32'h0);

    // Same-cycle read of the register being written.
    step("same_setup", 1'b1, 1'b1, 5'd3, 32'h00000011, 5'd0, 5'd0);
    rst_n = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h22; raddr1 = 5'd3; raddr2 = 5'd3;
    #2;
    expect_const("same_cycle", rdata1, BYPASS ? 32'h22 : 32'h11);
    step("same_write", 1'b1, 1'b1, 5'd3, 32'h00000022, 5'd3, 5'd3);
    step("same_next", 1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    expect_const("same_next_r3", rdata1, 32'h22);

    // Dual-port aliasing and we gating.
    step("alias_w12", 1'b1, 1'b1, 5'd12, 32'h5A5A5A5A, 5'd12, 5'd12);
    step("alias_we0", 1'b1, 1'b0, 5'd12, 32'h0, 5'd12, 5'd12);
    step("alias_after", 1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
    expect_const("alias_p1", rdata1, 32'h5A5A5A5A);
    expect_const("alias_p2", rdata2, 32'h5A5A5A5A);

    // Reset mid write sequence.
    step("mid_w1", 1'b1, 1'b1, 5'd1, 32'hA1A1A1A1, 5'd1, 5'd2);
    step("mid_w2_rst", 1'b0, 1'b1, 5'd2, 32'hB2B2B2B2, 5'd1, 5'd2);
    step("mid_w3", 1'b1, 1'b1, 5'd3, 32'hC3C3C3C3, 5'd1, 5'd2);
    step("mid_read", 1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd1);
    expect_const("mid_r3", rdata1, 32'hC3C3C3C3);
    expect_const("mid_r1", rdata2, 32'h0);

    // Random traffic with hazards and occasional resets.
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 24) != 0);
      w   = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? ra1 : 5'($urandom_range(0, 31));
      step("random", r, w, wa, wd, ra1, ra2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

MIPS general-purpose register file: 32 × 32-bit registers, two asynchronous read ports, one synchronous write port. Sits directly downstream of the writeback data mux (MemtoReg select), consuming its output as write data. Its two read outputs feed the ALU operand path, including the ALUSrc mux. Register 0 is hardwired to zero, per the MIPS ISA.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS

- clk  input  1  single clock; all state updates occur on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- we  input  1  write enable (RegWrite)
- waddr  input  ADDR_W  write register index (RegDst mux output)
- wdata  input  DATA_W  write data (writeback mux output)
- raddr1  input  ADDR_W  read port 1 index (rs)
- raddr2  input  ADDR_W  read port 2 index (rt)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data

## Operation
- Storage: NUM_REGS entries, each DATA_W bits.
- Write:
  - On rising clk with rst_n=1, we=1 and waddr≠0: entry[waddr] ← wdata.
  - A write to waddr=0 is discarded. Entry 0 always reads 0.
- Read:
  - Combinational. rdataN = entry[raddrN].
  - raddrN=0 always yields 0, regardless of stored state or bypass.
- Reset:
  - On rising clk with rst_n=0, every entry clears to 0.
  - Any write presented in that cycle is dropped, even if we=1.
  - Reset asserted in the middle of a write sequence behaves the same way: the write in that cycle is dropped and all prior contents clear.
- Both read ports may address the same register. Each returns the identical value.
- No state machine: the block holds state only. Each entry updates independently, gated by the decoded write enable.

## Timing
- Write latency:
  - A write presented in cycle N becomes visible on the read ports after the rising edge ending cycle N.
  - With bypass enabled (see Configuration), the value is visible in cycle N itself.
- Read latency: zero cycles. Read data is combinational from raddr and the stored entries.
- Reset values:
  - After the first rising edge with rst_n=0, rdata1=rdata2=0 for every address.
  - Before that first edge, contents are undefined, except that address 0 reads 0.
- Simultaneous read and write to the same non-zero register in one cycle:
  - Without bypass: the read returns the old value.
  - With bypass: the read returns wdata.
- While rst_n=0 the bypass path is inhibited: reads return stored contents, never wdata.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - If we=1, rst_n=1, waddr≠0 and raddrN==waddr, then rdataN = wdata in the same cycle (write-through forwarding).
  - Used by the pipelined datapath to resolve the writeback-to-decode hazard.
- Undefined:
  - Reads always return stored contents.
  - This is the single-cycle datapath behaviour.
- Port list and reset behaviour are identical in both builds.

## Structure
- Shared package mips_pkg holds:
  - REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32
  - REG_ZERO = 5'd0
  - The reg_addr_t and word_t typedefs, also used by the datapath muxes and the ALU.
- Sub-module reg_file_rd_port is natural, instantiated twice. It contains:
  - The read select from the storage array.
  - The zero-register force.
  - The REG_FILE_BYPASS_EN comparator.
- Storage array, write decode and reset clear live in reg_file itself.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r5, then hold rst_n=0 for 1 cycle.
  - Expected: raddr1=5 returns 0. A write attempted during the reset cycle (we=1, waddr=7, wdata=0x1234) leaves r7=0.
- Basic write/read:
  - Stimulus: write 0x0000_00AA to r8 and 0xFFFF_0001 to r31 in consecutive cycles. Then set raddr1=8, raddr2=31.
  - Expected: rdata1=0x0000_00AA, rdata2=0xFFFF_0001.
- Zero register:
  - Stimulus: we=1, waddr=0, wdata=0xFFFFFFFF. Then read raddr1=raddr2=0.
  - Expected: both outputs 0, in both builds and including the write cycle itself.
- Same-cycle read of the written register:
  - Setup: r3=0x11. Stimulus: write 0x22 to r3 while raddr1=3.
  - Expected during the write cycle: rdata1=0x11 without REG_FILE_BYPASS_EN, 0x22 with it.
  - Expected next cycle: 0x22 in both builds.
- Dual-port aliasing and we gating:
  - Stimulus: raddr1=raddr2=12 with r12=0x5A5A5A5A. Then we=0, waddr=12, wdata=0.
  - Expected: both ports read 0x5A5A5A5A before and after the we=0 cycle.
- Reset mid-sequence:
  - Stimulus: back-to-back writes to r1, r2, r3. Assert rst_n=0 on the r2 cycle.
  - Expected: r1=0 and r2=0 afterwards. The r3 write, in the cycle after reset deasserts, lands normally.
